punc_control: RTL and testbench

Control unit for the PUnC LC3 processor. It is a multi-cycle state machine that sequences the PUnC datapath through reset, fetch, decode and execute. It decodes the 16-bit instruction register and drives every datapath load, enable and select line. Condition codes come back from the datapath for branch resolution.

---
 rtl/punc_control.sv | 219 +++++++++++++++++++++
 tb/tb_punc_control.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_control.sv
`default_nettype none
// ============================================================================
// Module      : punc_control
// Description : Multi-cycle control unit for the PUnC LC3 processor.
//               It sequences the datapath through INIT, FETCH, DECODE, EXEC
//               and EXEC2. It decodes the instruction register into datapath
//               load, enable and select lines.
// Revision    : 1.0 - initial release
// ============================================================================
module punc_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        n,
    input  logic        z,
    input  logic        p,
    output logic        mem_w_en,
    output logic        mem_w_addr_sel,
    output logic        mem_w_data_sel,
    output logic [1:0]  mem_r_addr_sel,
    output logic        rf_w_en,
    output logic        rf_r0_addr_sel,
    output logic        rf_r1_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        ir_ld,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_ld_data_sel,
    output logic [2:0]  alu_sel,
    output logic        cond_ld,
    output logic        cond_ld_data_sel,
    output logic        halted,
    output logic [2:0]  state_debug
);

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] c_OP_BR   = 4'b0000;
    localparam logic [3:0] c_OP_ADD  = 4'b0001;
    localparam logic [3:0] c_OP_LD   = 4'b0010;
    localparam logic [3:0] c_OP_ST   = 4'b0011;
    localparam logic [3:0] c_OP_JSR  = 4'b0100;
    localparam logic [3:0] c_OP_AND  = 4'b0101;
    localparam logic [3:0] c_OP_LDR  = 4'b0110;
    localparam logic [3:0] c_OP_STR  = 4'b0111;
    localparam logic [3:0] c_OP_NOT  = 4'b1001;
    localparam logic [3:0] c_OP_LDI  = 4'b1010;
    localparam logic [3:0] c_OP_STI  = 4'b1011;
    localparam logic [3:0] c_OP_JMP  = 4'b1100;
    localparam logic [3:0] c_OP_LEA  = 4'b1110;
    localparam logic [3:0] c_OP_HALT = 4'b1111;

    localparam logic [2:0] c_ALU_ADD  = 3'd0;
    localparam logic [2:0] c_ALU_ADDI = 3'd1;
    localparam logic [2:0] c_ALU_NOT  = 3'd2;
    localparam logic [2:0] c_ALU_AND  = 3'd3;
    localparam logic [2:0] c_ALU_ANDI = 3'd4;

    state_t     r_state;
    logic [3:0] w_opcode;
    logic       w_imm_mode;
    logic       w_br_taken;
    logic       w_unused_ir;

    assign w_opcode    = ir[15:12];
    assign w_imm_mode  = ir[5];
    // An nzp field of 000 can never match, so it never branches.
    assign w_br_taken  = (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
    // Register and offset fields are consumed by the datapath, not here.
    assign w_unused_ir = ^{ir[8:6], ir[4:0]};

    assign halted      = (r_state == S_HALT);
    assign state_debug = r_state;

    // State register: sequence FETCH/DECODE/EXEC, with an extra EXEC2 for indirects.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
        end else begin
            case (r_state)
                S_INIT:   r_state <= S_FETCH;
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: r_state <= S_EXEC;
                S_EXEC: begin
                    if (w_opcode == c_OP_LDI || w_opcode == c_OP_STI)
                        r_state <= S_EXEC2;
                    else if (w_opcode == c_OP_HALT)
                        r_state <= S_HALT;
                    else
                        r_state <= S_FETCH;
                end
                S_EXEC2:  r_state <= S_FETCH;
                S_HALT:   r_state <= S_HALT;
                default:  r_state <= S_INIT;
            endcase
        end
    end

    // Control decode from state and IR; reset suppresses every strobe except pc_clr.
    always_comb begin
        mem_w_en         = 1'b0;
        mem_w_addr_sel   = 1'b0;
        mem_w_data_sel   = 1'b0;
        mem_r_addr_sel   = 2'd0;
        rf_w_en          = 1'b0;
        rf_r0_addr_sel   = 1'b0;
        rf_r1_addr_sel   = 1'b0;
        rf_w_data_sel    = 2'd0;
        rf_w_addr_sel    = 1'b0;
        ir_ld            = 1'b0;
        pc_ld            = 1'b0;
        pc_clr           = 1'b0;
        pc_inc           = 1'b0;
        pc_ld_data_sel   = 2'd0;
        alu_sel          = 3'd0;
        cond_ld          = 1'b0;
        cond_ld_data_sel = 1'b0;

        if (rst) begin
            pc_clr = 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    pc_clr = 1'b1;
                end
                S_FETCH: begin
                    mem_r_addr_sel = 2'd0;
                    ir_ld          = 1'b1;
                    pc_inc         = 1'b1;
                end
                S_EXEC: begin
                    case (w_opcode)
                        c_OP_ADD, c_OP_AND, c_OP_NOT: begin
                            if (w_opcode == c_OP_NOT)
                                alu_sel = c_ALU_NOT;
                            else if (w_opcode == c_OP_ADD)
                                alu_sel = w_imm_mode ? c_ALU_ADDI : c_ALU_ADD;
                            else
                                alu_sel = w_imm_mode ? c_ALU_ANDI : c_ALU_AND;
                            // Register mode reads SR2 on port 1 (field B).
                            rf_r1_addr_sel = (w_opcode != c_OP_NOT) && !w_imm_mode;
                            rf_w_en        = 1'b1;
                            cond_ld        = 1'b1;
                        end
                        c_OP_BR: begin
                            pc_ld = w_br_taken;
                        end
                        c_OP_JMP: begin
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = 2'd1;
                        end
                        c_OP_JSR: begin
                            // R7 captures the pre-jump PC on the same edge as the jump.
                            rf_w_en        = 1'b1;
                            rf_w_addr_sel  = 1'b1;
                            rf_w_data_sel  = 2'd2;
                            pc_ld          = 1'b1;
                            pc_ld_data_sel = ir[11] ? 2'd2 : 2'd1;
                        end
                        c_OP_LD, c_OP_LDR: begin
                            mem_r_addr_sel   = (w_opcode == c_OP_LD) ? 2'd1 : 2'd2;
                            rf_w_data_sel    = 2'd1;
                            rf_w_en          = 1'b1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        c_OP_LEA: begin
                            rf_w_data_sel    = 2'd3;
                            rf_w_en          = 1'b1;
                            cond_ld          = 1'b1;
                            cond_ld_data_sel = 1'b1;
                        end
                        c_OP_ST: begin
                            mem_w_en = 1'b1;
                        end
                        c_OP_STR: begin
                            mem_w_en       = 1'b1;
                            mem_w_addr_sel = 1'b1;
                            rf_r1_addr_sel = 1'b1;
                        end
                        c_OP_LDI, c_OP_STI: begin
                            // First half of an indirect: fetch the pointer word.
                            mem_r_addr_sel = 2'd1;
                        end
                        default: begin
                            // Reserved opcodes and HALT assert nothing.
                        end
                    endcase
                end
                S_EXEC2: begin
                    // Second half of an indirect: access through the latched pointer.
                    mem_r_addr_sel = 2'd3;
                    if (w_opcode == c_OP_LDI) begin
                        rf_w_data_sel    = 2'd1;
                        rf_w_en          = 1'b1;
                        cond_ld          = 1'b1;
                        cond_ld_data_sel = 1'b1;
                    end else if (w_opcode == c_OP_STI) begin
                        mem_w_en = 1'b1;
                    end
                end
                default: begin
                    // DECODE and HALT drive nothing.
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_punc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_punc_control
// Description : Table-driven self-checking bench for punc_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic       mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
    } ctrl_t;

    typedef struct {
        logic [15:0] ir;
        logic        n, z, p;
        ctrl_t       exp;
        logic [2:0]  nxt;
        ctrl_t       exp2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ir  = 16'h0;
    logic        n = 1'b0, z = 1'b0, p = 1'b0;

    logic        mem_w_en, mem_w_addr_sel, mem_w_data_sel;
    logic [1:0]  mem_r_addr_sel;
    logic        rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_ld_data_sel;
    logic [2:0]  alu_sel;
    logic        cond_ld, cond_ld_data_sel, halted;
    logic [2:0]  state_debug;
    ctrl_t       act;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    punc_control dut (
        .clk(clk), .rst(rst), .ir(ir), .n(n), .z(z), .p(p),
        .mem_w_en(mem_w_en), .mem_w_addr_sel(mem_w_addr_sel),
        .mem_w_data_sel(mem_w_data_sel), .mem_r_addr_sel(mem_r_addr_sel),
        .rf_w_en(rf_w_en), .rf_r0_addr_sel(rf_r0_addr_sel),
        .rf_r1_addr_sel(rf_r1_addr_sel), .rf_w_data_sel(rf_w_data_sel),
        .rf_w_addr_sel(rf_w_addr_sel), .ir_ld(ir_ld), .pc_ld(pc_ld),
        .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld_data_sel(pc_ld_data_sel),
        .alu_sel(alu_sel), .cond_ld(cond_ld), .cond_ld_data_sel(cond_ld_data_sel),
        .halted(halted), .state_debug(state_debug)
    );

    assign act = {mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
                  rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel,
                  rf_w_addr_sel, ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel,
                  alu_sel, cond_ld, cond_ld_data_sel};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_c(input string nm, input ctrl_t a, input ctrl_t x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: controls got %h expected %h", nm, a, x);
        end
    endtask

    task automatic chk_v(input string nm, input logic [15:0] a, input logic [15:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, x);
        end
    endtask

    task automatic add(input logic [15:0] i, input logic nn, input logic zz, input logic pp,
                       input ctrl_t e, input logic [2:0] nx, input ctrl_t e2);
        vec_t v;
        v.ir = i; v.n = nn; v.z = zz; v.p = pp;
        v.exp = e; v.nxt = nx; v.exp2 = e2;
        vecs.push_back(v);
    endtask

    // Reset, then walk INIT -> FETCH -> DECODE -> EXEC with the given IR.
    task automatic run_to_exec(input logic [15:0] i, input string nm);
        ctrl_t c_init, c_fetch;
        c_init = '0;  c_init.pc_clr = 1'b1;
        c_fetch = '0; c_fetch.ir_ld = 1'b1; c_fetch.pc_inc = 1'b1;
        ir = i;
        rst = 1'b1;
        step();
        chk_v({nm, " rst state"}, 16'(state_debug), 16'd0);
        chk_c({nm, " rst ctrl"}, act, c_init);
        chk_v({nm, " rst halted"}, 16'(halted), 16'd0);
        rst = 1'b0;
        #1;
        chk_c({nm, " init ctrl"}, act, c_init);
        step();
        chk_v({nm, " fetch state"}, 16'(state_debug), 16'd1);
        chk_c({nm, " fetch ctrl"}, act, c_fetch);
        step();
        chk_v({nm, " decode state"}, 16'(state_debug), 16'd2);
        chk_c({nm, " decode ctrl"}, act, '0);
        step();
        chk_v({nm, " exec state"}, 16'(state_debug), 16'd3);
    endtask

    initial begin
        ctrl_t e, e2, zero, c_init;
        zero = '0;
        c_init = '0; c_init.pc_clr = 1'b1;

        // ---------------- vector table ----------------
        e = '0; e.alu_sel = 3'd1; e.rf_w_en = 1; e.cond_ld = 1;
        add(16'h1265, 0, 0, 0, e, 3'd1, zero);                 // ADD imm
        e = '0; e.alu_sel = 3'd0; e.rf_r1_addr_sel = 1; e.rf_w_en = 1; e.cond_ld = 1;
        add(16'h1042, 0, 0, 0, e, 3'd1, zero);                 // ADD reg
        e = '0; e.alu_sel = 3'd4; e.rf_w_en = 1; e.cond_ld = 1;
        add(16'h5260, 0, 0, 0, e, 3'd1, zero);                 // AND imm
        e = '0; e.alu_sel = 3'd3; e.rf_r1_addr_sel = 1; e.rf_w_en = 1; e.cond_ld = 1;
        add(16'h5042, 0, 0, 0, e, 3'd1, zero);                 // AND reg
        e = '0; e.alu_sel = 3'd2; e.rf_w_en = 1; e.cond_ld = 1;
        add(16'h927F, 0, 0, 0, e, 3'd1, zero);                 // NOT
        e = '0; e.pc_ld = 1;
        add(16'h0E02, 0, 1, 0, e, 3'd1, zero);                 // BRnzp, z
        add(16'h0002, 0, 1, 0, zero, 3'd1, zero);              // BR nzp=000
        add(16'h0802, 0, 1, 0, zero, 3'd1, zero);              // BRn, z only
        add(16'h0802, 1, 0, 0, e, 3'd1, zero);                 // BRn, n
        add(16'h0402, 0, 1, 0, e, 3'd1, zero);                 // BRz, z
        add(16'h0202, 0, 0, 1, e, 3'd1, zero);                 // BRp, p
        add(16'h0202, 1, 1, 0, zero, 3'd1, zero);              // BRp, n z
        e = '0; e.pc_ld = 1; e.pc_ld_data_sel = 2'd1;
        add(16'hC1C0, 0, 0, 0, e, 3'd1, zero);                 // JMP
        e = '0; e.rf_w_en = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd2;
        e.pc_ld = 1; e.pc_ld_data_sel = 2'd2;
        add(16'h4802, 0, 0, 0, e, 3'd1, zero);                 // JSR
        e.pc_ld_data_sel = 2'd1;
        add(16'h4080, 0, 0, 0, e, 3'd1, zero);                 // JSRR
        e = '0; e.mem_r_addr_sel = 2'd1; e.rf_w_data_sel = 2'd1; e.rf_w_en = 1;
        e.cond_ld = 1; e.cond_ld_data_sel = 1;
        add(16'h2203, 0, 0, 0, e, 3'd1, zero);                 // LD
        e.mem_r_addr_sel = 2'd2;
        add(16'h6283, 0, 0, 0, e, 3'd1, zero);                 // LDR
        e = '0; e.rf_w_data_sel = 2'd3; e.rf_w_en = 1; e.cond_ld = 1; e.cond_ld_data_sel = 1;
        add(16'hE203, 0, 0, 0, e, 3'd1, zero);                 // LEA
        e = '0; e.mem_w_en = 1;
        add(16'h3203, 0, 0, 0, e, 3'd1, zero);                 // ST
        e = '0; e.mem_w_en = 1; e.mem_w_addr_sel = 1; e.rf_r1_addr_sel = 1;
        add(16'h7283, 0, 0, 0, e, 3'd1, zero);                 // STR
        e = '0; e.mem_r_addr_sel = 2'd1;
        e2 = '0; e2.mem_r_addr_sel = 2'd3; e2.rf_w_data_sel = 2'd1; e2.rf_w_en = 1;
        e2.cond_ld = 1; e2.cond_ld_data_sel = 1;
        add(16'hA203, 0, 0, 0, e, 3'd4, e2);                   // LDI
        e2 = '0; e2.mem_r_addr_sel = 2'd3; e2.mem_w_en = 1;
        add(16'hB203, 0, 0, 0, e, 3'd4, e2);                   // STI
        add(16'h8000, 1, 1, 1, zero, 3'd1, zero);              // reserved 1000
        add(16'hD000, 1, 1, 1, zero, 3'd1, zero);              // reserved 1101

        // ---------------- apply table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            string nm;
            nm = $sformatf("v%0d ir=%h", i, vecs[i].ir);
            n = vecs[i].n; z = vecs[i].z; p = vecs[i].p;
            run_to_exec(vecs[i].ir, nm);
            chk_c({nm, " exec ctrl"}, act, vecs[i].exp);
            step();
            chk_v({nm, " after exec"}, 16'(state_debug), 16'(vecs[i].nxt));
            if (vecs[i].nxt == 3'd4) begin
                chk_c({nm, " exec2 ctrl"}, act, vecs[i].exp2);
                step();
                chk_v({nm, " after exec2"}, 16'(state_debug), 16'd1);
            end
        end

        // ---------------- HALT is absorbing until rst ----------------
        n = 0; z = 0; p = 0;
        run_to_exec(16'hF025, "halt");
        chk_c("halt exec ctrl", act, zero);
        chk_v("halt exec halted", 16'(halted), 16'd0);
        for (int k = 0; k < 22; k++) begin
            step();
            chk_v($sformatf("halt c%0d state", k), 16'(state_debug), 16'd5);
            chk_v($sformatf("halt c%0d halted", k), 16'(halted), 16'd1);
            chk_c($sformatf("halt c%0d ctrl", k), act, zero);
        end
        rst = 1'b1;
        step();
        chk_v("halt rst state", 16'(state_debug), 16'd0);
        chk_v("halt rst halted", 16'(halted), 16'd0);
        rst = 1'b0;
        #1;
        chk_c("halt rst init ctrl", act, c_init);
        step();
        chk_v("halt rst fetch", 16'(state_debug), 16'd1);

        // ---------------- rst during EXEC2 of STI ----------------
        run_to_exec(16'hB203, "sti rst");
        step();
        chk_v("sti rst exec2 state", 16'(state_debug), 16'd4);
        chk_v("sti rst exec2 wen", 16'(mem_w_en), 16'd1);
        rst = 1'b1;
        #1;
        chk_v("sti rst wen gated", 16'(mem_w_en), 16'd0);
        step();
        chk_v("sti rst next state", 16'(state_debug), 16'd0);
        rst = 1'b0;

        // ---------------- CPI for ADD: back in FETCH three edges later ----------------
        run_to_exec(16'h1265, "cpi");
        step();
        chk_v("cpi fetch again", 16'(state_debug), 16'd1);
        step();
        chk_v("cpi decode again", 16'(state_debug), 16'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
